wbm_row_collector: RTL and testbench

WBM_ROW_COLLECTOR -- requirements
Module: wbm_row_collector

---
 rtl/wbm_row_collector.sv | 116 +++++++++++
 tb/tb_wbm_row_collector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_row_collector.sv
// Wishbone master that reads rows of three words and writes each row out.
// Ports: Clock/Reset, iEnable start, Wishbone read master, row write side.
module wbm_row_collector #(
  parameter int WIDTH              = 32,
  parameter int DATA_ADDRESS_WIDTH = 16,
  parameter int COUNT_WIDTH        = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iEnable,
  input  logic [WIDTH-1:0]              iBusAddress,
  input  logic [COUNT_WIDTH-1:0]        iRowCount,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iAdr_DataWriteBack,
  output logic [WIDTH-1:0]              ADR_O,
  output logic                          STB_O,
  output logic                          CYC_O,
  output logic                          WE_O,
  input  logic [WIDTH-1:0]              DAT_I,
  input  logic                          ACK_I,
  output logic [3*WIDTH-1:0]            oDataBus,
  output logic [DATA_ADDRESS_WIDTH-1:0] oDataWriteAddress,
  output logic                          oDataWriteEnable,
  output logic                          oBusy,
  output logic                          oDone
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [WIDTH-1:0]              adr_q, adr_d;
  logic [3*WIDTH-1:0]            data_q, data_d;
  logic [DATA_ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
  logic [COUNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [1:0]                    idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    data_d  = data_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (iEnable) begin
          if (iRowCount != '0) begin
            adr_d   = iBusAddress;
            cnt_d   = iRowCount;
            wptr_d  = iAdr_DataWriteBack;
            idx_d   = 2'd0;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (ACK_I) begin
          // element 0 is X, placed in the top slot
          case (idx_q)
            2'd0:    data_d[3*WIDTH-1 -: WIDTH] = DAT_I;
            2'd1:    data_d[2*WIDTH-1 -: WIDTH] = DAT_I;
            default: data_d[WIDTH-1:0]          = DAT_I;
          endcase
          adr_d = adr_q + WIDTH'(1);
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        wptr_d  = wptr_q + DATA_ADDRESS_WIDTH'(1);
        cnt_d   = cnt_q - COUNT_WIDTH'(1);
        state_d = (cnt_q == COUNT_WIDTH'(1)) ? S_DONE : S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      data_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign ADR_O             = adr_q;
  assign STB_O             = (state_q == S_REQ);
  assign CYC_O             = (state_q == S_REQ) || (state_q == S_WRITE);
  assign WE_O              = 1'b0;
  assign oDataBus          = data_q;
  assign oDataWriteAddress = wptr_q;
  assign oDataWriteEnable  = (state_q == S_WRITE);
  assign oBusy             = (state_q != S_IDLE);
  assign oDone             = (state_q == S_DONE);

endmodule

// File: tb/tb_wbm_row_collector.sv
// Directed bench for wbm_row_collector with a wait-state Wishbone slave.
// Ports: none.
module tb_wbm_row_collector;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        iEnable = 1'b0;
  logic [31:0] iBusAddress = '0;
  logic [7:0]  iRowCount = '0;
  logic [15:0] iAdr = '0;
  logic [31:0] ADR_O;
  logic        STB_O, CYC_O, WE_O;
  logic [31:0] DAT_I;
  logic        ACK_I;
  logic [95:0] oDataBus;
  logic [15:0] oDataWriteAddress;
  logic        oDataWriteEnable, oBusy, oDone;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] off = '0;

  logic [15:0] wq_a[$];
  logic [95:0] wq_d[$];
  logic [31:0] aq[$];
  int          n_stb = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  int          st = 0;
  int          b_w, b_a, b_s, b_d;

  always #5 clk = ~clk;

  wbm_row_collector dut (
    .Clock             (clk),
    .Reset             (Reset),
    .iEnable           (iEnable),
    .iBusAddress       (iBusAddress),
    .iRowCount         (iRowCount),
    .iAdr_DataWriteBack(iAdr),
    .ADR_O             (ADR_O),
    .STB_O             (STB_O),
    .CYC_O             (CYC_O),
    .WE_O              (WE_O),
    .DAT_I             (DAT_I),
    .ACK_I             (ACK_I),
    .oDataBus          (oDataBus),
    .oDataWriteAddress (oDataWriteAddress),
    .oDataWriteEnable  (oDataWriteEnable),
    .oBusy             (oBusy),
    .oDone             (oDone)
  );

  assign ACK_I = force_ack | (STB_O && wcnt == wait_n);
  assign DAT_I = ADR_O + off;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Reset || !STB_O || ACK_I) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (STB_O) n_stb <= n_stb + 1;
    if (STB_O && ACK_I) aq.push_back(ADR_O);
    if (oDataWriteEnable) begin
      wq_a.push_back(oDataWriteAddress);
      wq_d.push_back(oDataBus);
    end
    if (oDone) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_w = wq_a.size();
    b_a = aq.size();
    b_s = n_stb;
    b_d = n_done;
  endtask

  task automatic start(input logic [31:0] a,
                       input logic [7:0]  n,
                       input logic [15:0] w);
    @(negedge clk);
    mark();
    iBusAddress = a;
    iRowCount   = n;
    iAdr        = w;
    iEnable     = 1'b1;
    @(posedge clk);
    #1;
    st      = cyc;
    iEnable = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done == b_d && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("timeout", 96'(n_done != b_d), 96'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    check("rst_adr", 96'(ADR_O), 96'd0);
    check("rst_stb", 96'(STB_O), 96'd0);
    check("rst_cyc", 96'(CYC_O), 96'd0);
    check("rst_we", 96'(WE_O), 96'd0);
    check("rst_data", oDataBus, 96'd0);
    check("rst_wa", 96'(oDataWriteAddress), 96'd0);
    check("rst_wen", 96'(oDataWriteEnable), 96'd0);
    check("rst_busy", 96'(oBusy), 96'd0);
    check("rst_done", 96'(oDone), 96'd0);

    // one row, zero wait, data 0xA 0xB 0xC
    wait_n = 0;
    off    = 32'h0000000A - 32'h00000100;
    start(32'h100, 8'd1, 16'h20);
    wait_done();
    check("t1_lat", 96'(done_cyc - st + 1), 96'd5);
    check("t1_nw", 96'(wq_a.size() - b_w), 96'd1);
    check("t1_wa", 96'(wq_a[b_w]), 96'h20);
    check("t1_wd", wq_d[b_w],
          96'h0000000A_0000000B_0000000C);
    check("t1_adr", 96'(ADR_O), 96'h103);
    check("t1_hold", oDataBus,
          96'h0000000A_0000000B_0000000C);

    // two rows, two wait states per word
    wait_n = 2;
    off    = 32'h1000;
    start(32'h100, 8'd2, 16'h20);
    wait_done();
    check("t2_lat", 96'(done_cyc - st + 1), 96'd21);
    check("t2_nack", 96'(aq.size() - b_a), 96'd6);
    check("t2_a0", 96'(aq[b_a]), 96'h100);
    check("t2_a5", 96'(aq[b_a+5]), 96'h105);
    check("t2_stb", 96'(n_stb - b_s), 96'd18);
    check("t2_nw", 96'(wq_a.size() - b_w), 96'd2);
    check("t2_wa0", 96'(wq_a[b_w]), 96'h20);
    check("t2_wa1", 96'(wq_a[b_w+1]), 96'h21);
    check("t2_wd0", wq_d[b_w],
          96'h00001100_00001101_00001102);
    check("t2_wd1", wq_d[b_w+1],
          96'h00001103_00001104_00001105);

    // zero rows
    wait_n = 0;
    start(32'h500, 8'd0, 16'h70);
    wait_done();
    check("t3_lat", 96'(done_cyc - st + 1), 96'd1);
    check("t3_stb", 96'(n_stb - b_s), 96'd0);
    check("t3_nw", 96'(wq_a.size() - b_w), 96'd0);

    // address and write-pointer wrap
    off = 32'h0;
    start(32'hFFFFFFFF, 8'd2, 16'hFFFF);
    wait_done();
    check("t4_a1", 96'(aq[b_a+1]), 96'h0);
    check("t4_wa0", 96'(wq_a[b_w]), 96'hFFFF);
    check("t4_wa1", 96'(wq_a[b_w+1]), 96'h0000);
    check("t4_wd0", wq_d[b_w],
          96'hFFFFFFFF_00000000_00000001);
    check("t4_wd1", wq_d[b_w+1],
          96'h00000002_00000003_00000004);
    check("t4_adr", 96'(ADR_O), 96'h5);

    // reset after second ACK of first row
    start(32'h200, 8'd2, 16'h40);
    @(posedge clk);
    @(posedge clk);
    #1;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    check("t5_busy", 96'(oBusy), 96'd0);
    check("t5_stb", 96'(STB_O), 96'd0);
    check("t5_cyc", 96'(CYC_O), 96'd0);
    check("t5_adr", 96'(ADR_O), 96'd0);
    check("t5_data", oDataBus, 96'd0);
    check("t5_wa", 96'(oDataWriteAddress), 96'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_nw", 96'(wq_a.size() - b_w), 96'd0);
    start(32'h300, 8'd1, 16'h50);
    wait_done();
    check("t5_wa1", 96'(wq_a[b_w]), 96'h50);
    check("t5_wd1", wq_d[b_w],
          96'h00000300_00000301_00000302);

    // iEnable while busy, stray ACK in IDLE
    wait_n = 2;
    start(32'h400, 8'd1, 16'h60);
    @(negedge clk);
    iBusAddress = 32'h900;
    iRowCount   = 8'd5;
    iAdr        = 16'h99;
    iEnable     = 1'b1;
    @(negedge clk);
    iEnable = 1'b0;
    wait_done();
    repeat (2) @(posedge clk);
    @(negedge clk);
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_nw", 96'(wq_a.size() - b_w), 96'd1);
    check("t6_wa", 96'(wq_a[b_w]), 96'h60);
    check("t6_wd", wq_d[b_w],
          96'h00000400_00000401_00000402);
    check("t6_adr", 96'(ADR_O), 96'h403);
    check("t6_data", oDataBus,
          96'h00000400_00000401_00000402);
    check("t6_wptr", 96'(oDataWriteAddress), 96'h61);
    check("t6_ndone", 96'(n_done - b_d), 96'd1);
    check("t6_busy", 96'(oBusy), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
